// File: rtl/fwd_operand_mux.sv
// -----------------------------------------------------------------------------
// fwd_operand_mux
//
// Operand-forwarding selector with a registered output stage. One instance
// sits between the ID-stage register file and each EX-stage ALU operand input.
//
// The operand comes from one of three places:
//   - the register-file read value,
//   - the youngest in-flight writeback stage whose destination matches, or
//   - the hard-wired zero register.
// If the chosen forwarding stage does not have its data yet (for example a
// load that is still outstanding), the request is held off by dropping
// in_ready, and the hazard cycle is counted.
//
// Parameters
//   W         operand data width
//   AW        register address width
//   NFWD      number of forwarding stages; index 0 is the youngest
//   ZERO_REG  1: address 0 always reads as 0 and never matches a forward
//   CW        width of the saturating hazard-cycle counter
//   SW        width of the source code (derived from NFWD; leave at default)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous pipeline flush; drops the held operand
//   in_valid / in_ready   request handshake from ID
//   rs_addr, rf_data      source register address and its register-file data
//   fwd_wen/rdy/addr/data per-stage forwarding info, stage i in slice i
//   out_valid / out_ready operand handshake towards EX
//   op_q, src_q           registered operand and where it came from
//                         (0 = rf, i+1 = stage i, NFWD+1 = zero register)
//   hazard                combinational: the selected stage is not ready
//   hazard_cnt            saturating count of stalled request cycles
// -----------------------------------------------------------------------------
module fwd_operand_mux #(
  parameter int W        = 32,
  parameter int AW       = 5,
  parameter int NFWD     = 3,
  parameter bit ZERO_REG = 1'b1,
  parameter int CW       = 16,
  parameter int SW       = $clog2(NFWD + 2)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [AW-1:0]       rs_addr,
  input  logic [W-1:0]        rf_data,
  input  logic [NFWD-1:0]     fwd_wen,
  input  logic [NFWD-1:0]     fwd_rdy,
  input  logic [NFWD*AW-1:0]  fwd_addr,
  input  logic [NFWD*W-1:0]   fwd_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        op_q,
  output logic [SW-1:0]       src_q,
  output logic                hazard,
  output logic [CW-1:0]       hazard_cnt
);

  // ---------------------------------------------------------------------------
  // Unpack per-stage fields and compute address matches
  // ---------------------------------------------------------------------------
  logic [AW-1:0] stage_addr [NFWD];
  logic [W-1:0]  stage_data [NFWD];
  logic [NFWD-1:0] match;
  logic            is_zero;

  // Address 0 is only special when the zero register is enabled.
  assign is_zero = ZERO_REG && (rs_addr == '0);

  generate
    for (genvar gi = 0; gi < NFWD; gi++) begin : g_stage
      assign stage_addr[gi] = fwd_addr[gi*AW +: AW];
      assign stage_data[gi] = fwd_data[gi*W +: W];
      assign match[gi]      = fwd_wen[gi] && (stage_addr[gi] == rs_addr) && !is_zero;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Priority selection: walk from oldest to youngest so that the lowest
  // matching index (youngest write) is the one left standing.
  // ---------------------------------------------------------------------------
  logic          sel_hit;
  logic          sel_rdy;
  logic [W-1:0]  sel_fwd_data;
  logic [SW-1:0] sel_fwd_code;
  logic [W-1:0]  sel_data;
  logic [SW-1:0] sel_code;

  always_comb begin
    sel_hit      = 1'b0;
    sel_rdy      = 1'b1;
    sel_fwd_data = '0;
    sel_fwd_code = '0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel_hit      = 1'b1;
        sel_rdy      = fwd_rdy[i];
        sel_fwd_data = stage_data[i];
        sel_fwd_code = SW'(i + 1);
      end
    end
  end

  always_comb begin
    sel_data = rf_data;
    sel_code = '0;
    if (is_zero) begin
      sel_data = '0;
      sel_code = SW'(NFWD + 1);
    end else if (sel_hit) begin
      sel_data = sel_fwd_data;
      sel_code = sel_fwd_code;
    end
  end

  // Only the winning stage's readiness matters; older stages are shadowed.
  assign hazard = in_valid && sel_hit && !sel_rdy;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic accept;

  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Output register. Flush only drops valid; the operand and source are kept
  // so nothing downstream sees them toggle needlessly.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      op_q      <= '0;
      src_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      op_q      <= sel_data;
      src_q     <= sel_code;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating hazard counter; survives flushes, cleared only by reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hazard_cnt <= '0;
    end else if (hazard && (hazard_cnt != {CW{1'b1}})) begin
      hazard_cnt <= hazard_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_operand_mux.sv
module tb_fwd_operand_mux;

  localparam int W = 32;
  localparam int AW = 5;
  localparam int NFWD = 3;
  localparam int SW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT a: default parameters
  logic                rst_n, flush, in_valid, in_ready, out_valid, out_ready, hazard;
  logic [AW-1:0]       rs_addr;
  logic [W-1:0]        rf_data, op_q;
  logic [NFWD-1:0]     fwd_wen, fwd_rdy;
  logic [NFWD*AW-1:0]  fwd_addr;
  logic [NFWD*W-1:0]   fwd_data;
  logic [SW-1:0]       src_q;
  logic [15:0]         hazard_cnt;

  // DUT b: 2-bit counter for saturation
  logic                b_rst_n, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_hazard;
  logic [AW-1:0]       b_rs_addr;
  logic [W-1:0]        b_rf_data, b_op_q;
  logic [NFWD-1:0]     b_fwd_wen, b_fwd_rdy;
  logic [NFWD*AW-1:0]  b_fwd_addr;
  logic [NFWD*W-1:0]   b_fwd_data;
  logic [SW-1:0]       b_src_q;
  logic [1:0]          b_hazard_cnt;

  fwd_operand_mux #(.W(W), .AW(AW), .NFWD(NFWD), .ZERO_REG(1'b1), .CW(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rf_data(rf_data), .fwd_wen(fwd_wen), .fwd_rdy(fwd_rdy),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
    .op_q(op_q), .src_q(src_q), .hazard(hazard), .hazard_cnt(hazard_cnt)
  );

  fwd_operand_mux #(.W(W), .AW(AW), .NFWD(NFWD), .ZERO_REG(1'b1), .CW(2)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .rs_addr(b_rs_addr), .rf_data(b_rf_data), .fwd_wen(b_fwd_wen), .fwd_rdy(b_fwd_rdy),
    .fwd_addr(b_fwd_addr), .fwd_data(b_fwd_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .op_q(b_op_q), .src_q(b_src_q), .hazard(b_hazard), .hazard_cnt(b_hazard_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance one clock edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rs_addr = '0; rf_data = '0; fwd_wen = '0; fwd_rdy = '0; fwd_addr = '0; fwd_data = '0;
    b_rst_n = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    b_rs_addr = '0; b_rf_data = '0; b_fwd_wen = '0; b_fwd_rdy = '0; b_fwd_addr = '0; b_fwd_data = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_op_q", 64'(op_q), 64'd0);
    check("rst_src_q", 64'(src_q), 64'd0);
    check("rst_hazard_cnt", 64'(hazard_cnt), 64'd0);
    rst_n = 1'b1; b_rst_n = 1'b1;
    step();

    // 1. No matches -> register file
    in_valid = 1'b1; rs_addr = 5'd5; rf_data = 32'h1111; fwd_wen = 3'b000; out_ready = 1'b1;
    #1;
    check("t1_in_ready", 64'(in_ready), 64'd1);
    step();
    check("t1_op_q", 64'(op_q), 64'h1111);
    check("t1_src_q", 64'(src_q), 64'd0);
    check("t1_out_valid", 64'(out_valid), 64'd1);

    // 2. Priority: stages 0 and 2 match r7, youngest wins; back-to-back accept
    rs_addr = 5'd7; fwd_wen = 3'b101; fwd_rdy = 3'b111;
    fwd_addr = {5'd7, 5'd9, 5'd7};
    fwd_data = {32'hCCCC, 32'hBBBB, 32'hAAAA};
    #1;
    check("t2_in_ready_b2b", 64'(in_ready), 64'd1);
    step();
    check("t2_op_q", 64'(op_q), 64'hAAAA);
    check("t2_src_q", 64'(src_q), 64'd1);
    check("t2_out_valid", 64'(out_valid), 64'd1);

    // 2b. Stage 0 off, stages 1 and 2 match -> stage 1
    fwd_wen = 3'b110; fwd_addr = {5'd7, 5'd7, 5'd7};
    step();
    check("t2b_op_q", 64'(op_q), 64'hBBBB);
    check("t2b_src_q", 64'(src_q), 64'd2);

    // 3. Zero register: stage 0 writes r0 (not ready) -> ignored
    rs_addr = 5'd0; fwd_wen = 3'b001; fwd_rdy = 3'b000;
    fwd_addr = {5'd0, 5'd0, 5'd0}; fwd_data = {32'h0, 32'h0, 32'hDEAD}; rf_data = 32'h9999;
    #1;
    check("t3_hazard", 64'(hazard), 64'd0);
    step();
    check("t3_op_q", 64'(op_q), 64'd0);
    check("t3_src_q", 64'(src_q), 64'd4);

    // 4. Load-use: stage 0 writes r3, not ready for 2 cycles
    rs_addr = 5'd3; fwd_wen = 3'b001; fwd_rdy = 3'b000;
    fwd_addr = {5'd0, 5'd0, 5'd3}; fwd_data = {32'h0, 32'h0, 32'h55};
    #1;
    check("t4_hazard_c0", 64'(hazard), 64'd1);
    check("t4_in_ready_c0", 64'(in_ready), 64'd0);
    step();
    check("t4_drained_out_valid", 64'(out_valid), 64'd0);
    check("t4_in_ready_c1", 64'(in_ready), 64'd0);
    step();
    check("t4_hazard_cnt", 64'(hazard_cnt), 64'd2);
    fwd_rdy = 3'b001;
    #1;
    check("t4_in_ready_rdy", 64'(in_ready), 64'd1);
    step();
    check("t4_op_q", 64'(op_q), 64'h55);
    check("t4_src_q", 64'(src_q), 64'd1);
    check("t4_hazard_cnt_hold", 64'(hazard_cnt), 64'd2);

    // 4b. Younger ready stage shadows an older pending one
    fwd_wen = 3'b011; fwd_rdy = 3'b001;
    fwd_addr = {5'd0, 5'd3, 5'd3}; fwd_data = {32'h0, 32'h77, 32'h66};
    #1;
    check("t4b_hazard", 64'(hazard), 64'd0);
    step();
    check("t4b_op_q", 64'(op_q), 64'h66);

    // 5. Backpressure then flush
    rs_addr = 5'd5; fwd_wen = 3'b000; rf_data = 32'h2222; out_ready = 1'b0;
    #1;
    check("t5_in_ready_bp", 64'(in_ready), 64'd0);
    step();
    check("t5_op_q_stall", 64'(op_q), 64'h66);
    check("t5_out_valid_stall", 64'(out_valid), 64'd1);
    flush = 1'b1;
    step();
    check("t5_flush_out_valid", 64'(out_valid), 64'd0);
    check("t5_flush_op_q_hold", 64'(op_q), 64'h66);
    check("t5_flush_in_ready", 64'(in_ready), 64'd0);
    step();
    check("t5_flush_no_accept", 64'(out_valid), 64'd0);
    check("t5_cnt_kept", 64'(hazard_cnt), 64'd2);
    flush = 1'b0;
    step();
    check("t5_after_flush_op_q", 64'(op_q), 64'h2222);
    in_valid = 1'b0; out_ready = 1'b1;

    // 6. Saturation on the CW=2 instance, then async reset mid-stall
    b_in_valid = 1'b1; b_rs_addr = 5'd5; b_rf_data = 32'h7;
    step();
    check("t6_b_op_q", 64'(b_op_q), 64'h7);
    b_rs_addr = 5'd3; b_fwd_wen = 3'b001; b_fwd_rdy = 3'b000;
    b_fwd_addr = {5'd0, 5'd0, 5'd3};
    repeat (5) step();
    check("t6_cnt_sat", 64'(b_hazard_cnt), 64'd3);
    check("t6_op_q_held", 64'(b_op_q), 64'h7);
    #2;
    b_rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 64'(b_out_valid), 64'd0);
    check("t6_rst_op_q", 64'(b_op_q), 64'd0);
    check("t6_rst_src_q", 64'(b_src_q), 64'd0);
    check("t6_rst_cnt", 64'(b_hazard_cnt), 64'd0);
    step();
    b_rst_n = 1'b1; b_in_valid = 1'b0;
    step();
    check("t6_post_rst_valid", 64'(b_out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
